syncnt_seq: RTL and testbench



---
 rtl/syncnt_seq_if.sv | 30 +++
 rtl/syncnt_seq.sv | 99 +++++++++
 tb/tb_syncnt_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/syncnt_seq_if.sv
// Control/status bundle between the sequencer and its loadable counter plus the host side.
// master = sequencer view, slave = host/counter view.
interface syncnt_seq_if #(
    parameter int W     = 3,
    parameter int WRAPW = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [W-1:0]     start_val;
    logic [W-1:0]     end_val;
    logic [W-1:0]     cnt_q;
    logic             cnt_en;
    logic             cnt_load;
    logic [W-1:0]     cnt_d;
    logic             busy;
    logic             done;
    logic             err;
    logic [WRAPW-1:0] wrap_cnt;

    modport master (
        input  start, stop, mode, start_val, end_val, cnt_q,
        output cnt_en, cnt_load, cnt_d, busy, done, err, wrap_cnt
    );

    modport slave (
        output start, stop, mode, start_val, end_val, cnt_q,
        input  cnt_en, cnt_load, cnt_d, busy, done, err, wrap_cnt
    );
endinterface

// File: rtl/syncnt_seq.sv
// Sequencer running a loadable counter from start_val to end_val (one-shot or periodic) with shadow checking.
// Latency: start at edge N -> load in cycle N+1 -> first count seen N+2; no backpressure, stop aborts to IDLE.
module syncnt_seq #(
    parameter int W     = 3,
    parameter int WRAPW = 8
) (
    input  logic          clk,
    input  logic          rst,
    syncnt_seq_if.master  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [WRAPW-1:0] WRAP_MAX = '1;

    state_t           state;
    logic [W-1:0]     sv;
    logic [W-1:0]     ev;
    logic             md;
    logic [W-1:0]     exp_q;
    logic             err_q;
    logic [WRAPW-1:0] wrap_q;

    logic             match;
    logic             at_end;
    logic             reload;
    logic             load_s;
    logic [WRAPW-1:0] wrap_inc;

    assign match    = (bus.cnt_q == exp_q);
    assign at_end   = (bus.cnt_q == ev);
    // Periodic reload is the only output that looks at the live counter value.
    assign reload   = (state == RUN) && match && at_end && md;
    assign load_s   = (state == LOAD) || reload;
    assign wrap_inc = (wrap_q == WRAP_MAX) ? wrap_q : wrap_q + 1'b1;

    assign bus.cnt_en   = (state == LOAD) || (state == RUN);
    assign bus.cnt_load = load_s;
    assign bus.cnt_d    = load_s ? sv : '0;
    assign bus.busy     = (state == LOAD) || (state == RUN);
    assign bus.done     = (state == DONE) && !bus.stop;
    assign bus.err      = err_q;
    assign bus.wrap_cnt = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sv     <= '0;
            ev     <= '0;
            md     <= 1'b0;
            exp_q  <= '0;
            err_q  <= 1'b0;
            wrap_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        sv     <= bus.start_val;
                        ev     <= bus.end_val;
                        md     <= bus.mode;
                        err_q  <= 1'b0;
                        wrap_q <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        state <= IDLE;
                    end else begin
                        exp_q <= sv;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
                    end else if (!match) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (!at_end) begin
                        exp_q <= exp_q + 1'b1;
                    end else if (md) begin
                        exp_q  <= sv;
                        wrap_q <= wrap_inc;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // An abort landing on the completion cycle suppresses the period count too.
                    if (!bus.stop) begin
                        wrap_q <= wrap_inc;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syncnt_seq.sv
// Bench for syncnt_seq: closes the loop with a loadable counter and checks against table vectors and a period model.
module tb_syncnt_seq;
    localparam int W     = 3;
    localparam int WRAPW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    syncnt_seq_if #(.W(W), .WRAPW(WRAPW)) bus ();

    syncnt_seq #(.W(W), .WRAPW(WRAPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Loadable counter the sequencer drives; flt overrides its output for fault injection.
    logic [W-1:0] ctr;
    logic         flt;
    logic [W-1:0] flt_val;
    always @(posedge clk) begin
        if (rst)               ctr <= '0;
        else if (bus.cnt_load) ctr <= bus.cnt_d;
        else if (bus.cnt_en)   ctr <= ctr + 1'b1;
    end
    assign bus.cnt_q = flt ? flt_val : ctr;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_out(input string tag, input int en, input int ld, input int d,
                           input int bsy, input int dn);
        chk({tag, ".en"},   bus.cnt_en,   en);
        chk({tag, ".load"}, bus.cnt_load, ld);
        chk({tag, ".d"},    bus.cnt_d,    d);
        chk({tag, ".busy"}, bus.busy,     bsy);
        chk({tag, ".done"}, bus.done,     dn);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [2:0] sv;
        logic [2:0] ev;
        logic       en;
        logic       ld;
        logic [2:0] d;
        logic [2:0] q;
        logic       busy;
        logic       done;
        logic [7:0] wrap;
    } vec_t;

    vec_t tbl[8];

    // Reference model: position within a period is k mod P, P = ((end-start) mod 8) + 1.
    task automatic run_check(input logic [2:0] sv, input logic [2:0] ev, input logic md,
                             input int ncyc_in, input string tag);
        int p;
        int pos;
        int wexp;
        int ncyc;
        logic term;
        p    = ((int'(ev) - int'(sv)) & 7) + 1;
        ncyc = md ? ncyc_in : p;
        wexp = 0;
        next_cycle;
        bus.start = 1'b1; bus.stop = 1'b0;
        bus.start_val = sv; bus.end_val = ev; bus.mode = md;
        #1;
        chk({tag, ".idle_busy"}, bus.busy, 0);
        next_cycle;
        bus.start = 1'b0;
        bus.start_val = 3'($urandom); bus.end_val = 3'($urandom); bus.mode = 1'($urandom);
        #1;
        chk_out({tag, ".load"}, 1, 1, int'(sv), 1, 0);
        for (int k = 0; k < ncyc; k++) begin
            next_cycle;
            pos  = k % p;
            term = (pos == p - 1);
            wexp = (k / p > 255) ? 255 : k / p;
            bus.stop = md && (k == ncyc - 1);
            #1;
            chk($sformatf("%s.q%0d", tag, k), bus.cnt_q, (int'(sv) + pos) % 8);
            chk_out($sformatf("%s.run%0d", tag, k), 1, int'(md && term),
                    (md && term) ? int'(sv) : 0, 1, 0);
            chk($sformatf("%s.err%0d", tag, k), bus.err, 0);
            chk($sformatf("%s.wrap%0d", tag, k), bus.wrap_cnt, wexp);
        end
        next_cycle;
        bus.stop = 1'b0;
        #1;
        if (!md) begin
            chk_out({tag, ".donest"}, 0, 0, 0, 0, 1);
            chk({tag, ".done_wrap"}, bus.wrap_cnt, 0);
            next_cycle;
            #1;
            chk_out({tag, ".post"}, 0, 0, 0, 0, 0);
            chk({tag, ".post_wrap"}, bus.wrap_cnt, 1);
        end else begin
            chk_out({tag, ".abort"}, 0, 0, 0, 0, 0);
            chk({tag, ".abort_wrap"}, bus.wrap_cnt, wexp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.start_val = '0; bus.end_val = '0;
        flt = 1'b0; flt_val = '0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd2, 3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b1, 8'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0, 8'd1};

        repeat (2) next_cycle;
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset.err", bus.err, 0);
        chk("reset.wrap", bus.wrap_cnt, 0);
        rst = 1'b0;

        // One-shot 2..5 with a start pulse and config changes while busy.
        for (int i = 0; i < 8; i++) begin
            next_cycle;
            bus.start = tbl[i].start; bus.stop = tbl[i].stop; bus.mode = tbl[i].mode;
            bus.start_val = tbl[i].sv; bus.end_val = tbl[i].ev;
            #1;
            chk_out($sformatf("tbl%0d", i), int'(tbl[i].en), int'(tbl[i].ld), int'(tbl[i].d),
                    int'(tbl[i].busy), int'(tbl[i].done));
            chk($sformatf("tbl%0d.q", i), bus.cnt_q, int'(tbl[i].q));
            chk($sformatf("tbl%0d.wrap", i), bus.wrap_cnt, int'(tbl[i].wrap));
        end

        run_check(3'd6, 3'd1, 1'b1, 17, "per_wrap");
        run_check(3'd3, 3'd3, 1'b1, 300, "degen");
        run_check(3'd2, 3'd5, 1'b0, 0, "oneshot");
        for (int r = 0; r < 20; r++) begin
            run_check(3'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(1, 40)),
                      $sformatf("rnd%0d", r));
        end

        // Fault injection: counter reads 4 where 3 is expected.
        next_cycle;
        bus.start = 1'b1; bus.start_val = 3'd0; bus.end_val = 3'd7; bus.mode = 1'b0;
        next_cycle;
        bus.start = 1'b0;
        repeat (3) next_cycle;
        next_cycle;
        flt = 1'b1; flt_val = 3'd4;
        #1;
        chk("flt.en", bus.cnt_en, 1);
        chk("flt.load", bus.cnt_load, 0);
        chk("flt.err_pre", bus.err, 0);
        next_cycle;
        flt = 1'b0;
        #1;
        chk("flt.err", bus.err, 1);
        chk("flt.busy", bus.busy, 0);
        chk("flt.en_after", bus.cnt_en, 0);
        repeat (3) next_cycle;
        #1;
        chk("flt.err_sticky", bus.err, 1);
        next_cycle;
        bus.start = 1'b1; bus.start_val = 3'd1; bus.end_val = 3'd1;
        next_cycle;
        bus.start = 1'b0;
        #1;
        chk("flt.err_clr", bus.err, 0);
        chk("flt.restart_busy", bus.busy, 1);
        next_cycle;
        next_cycle;
        #1;
        chk("flt.restart_done", bus.done, 1);

        // Abort at q=3 with a start pulse while busy.
        next_cycle;
        bus.start = 1'b1; bus.start_val = 3'd0; bus.end_val = 3'd6; bus.mode = 1'b0;
        next_cycle;
        bus.start = 1'b0;
        next_cycle;
        next_cycle;
        bus.start = 1'b1; bus.start_val = 3'd5;
        next_cycle;
        bus.start = 1'b0;
        next_cycle;
        bus.stop = 1'b1;
        #1;
        chk("abort.q", bus.cnt_q, 3);
        next_cycle;
        bus.stop = 1'b0;
        #1;
        chk_out("abort.idle", 0, 0, 0, 0, 0);
        chk("abort.wrap", bus.wrap_cnt, 0);
        repeat (2) next_cycle;
        #1;
        chk("abort.no_done", bus.done, 0);
        chk("abort.stay_idle", bus.busy, 0);

        // Synchronous reset during a periodic run with wrap_cnt already nonzero.
        next_cycle;
        bus.start = 1'b1; bus.start_val = 3'd2; bus.end_val = 3'd2; bus.mode = 1'b1;
        next_cycle;
        bus.start = 1'b0;
        repeat (5) next_cycle;
        #1;
        chk("rst.wrap_before", bus.wrap_cnt, 4);
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        #1;
        chk_out("rst.mid", 0, 0, 0, 0, 0);
        chk("rst.err", bus.err, 0);
        chk("rst.wrap", bus.wrap_cnt, 0);

        // start together with stop in IDLE stays idle.
        next_cycle;
        bus.start = 1'b1; bus.stop = 1'b1; bus.start_val = 3'd5; bus.end_val = 3'd6;
        next_cycle;
        bus.start = 1'b0; bus.stop = 1'b0;
        #1;
        chk_out("ss.idle", 0, 0, 0, 0, 0);
        next_cycle;
        #1;
        chk("ss.stay", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
